lfsr_checker_param: RTL

//  Parametrised PRBS/LFSR sequence checker for the BIST receive path. Compares each valid

---
 rtl/lfsr_pkg.sv | 35 +++
 rtl/lfsr_checker_param_if.sv | 26 ++
 rtl/lfsr_step.sv | 14 +
 rtl/lfsr_checker_param.sv | 127 ++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions for the PRBS checker and its matching generator.
// lfsr_next is written for words up to 32 bits; callers pass their real width.
package lfsr_pkg;

  typedef enum logic {ST_UNLOCKED = 1'b0, ST_LOCKED = 1'b1} state_e;

  localparam int MAXW   = 32;  // widest supported LFSR
  localparam int CNT_CW = 4;   // match/miss counter width, holds 1..15

  // Galois step with zero insertion: period 2^w, all-zeros included.
  function automatic logic [MAXW-1:0] lfsr_next(input logic [MAXW-1:0] s,
                                                input logic [MAXW-1:0] poly,
                                                input int              w);
    logic [MAXW-1:0] mask_w, mask_lo;
    logic            top, fb;
    mask_w  = (w >= MAXW) ? '1 : ((32'd1 << w) - 32'd1);
    mask_lo = mask_w >> 1;
    top     = |(s & mask_w & ~mask_lo);
    fb      = top ^ ((s & mask_lo) == '0);
    return ((s << 1) & mask_w) ^ (fb ? (poly & mask_w) : '0);
  endfunction

  function automatic logic [5:0] popcount(input logic [MAXW-1:0] v);
    logic [5:0]      c;
    logic [MAXW-1:0] t;
    c = '0;
    t = v;
    for (int i = 0; i < MAXW; i++) begin
      c = c + 6'(t[0]);
      t = t >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/lfsr_checker_param_if.sv
// Sample/control/status bundle between the deserialiser side and the checker.
interface lfsr_checker_param_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             i_valid;
  logic [WIDTH-1:0] i_lfsr;
  logic [WIDTH-1:0] i_seed;
  logic             i_seed_load;
  logic             i_clr_cnt;
  logic             o_lock;
  logic             o_match;
  logic             o_err;
  logic [CNT_W-1:0] o_word_err_cnt;
  logic [CNT_W-1:0] o_bit_err_cnt;

  modport master (
    output i_valid, i_lfsr, i_seed, i_seed_load, i_clr_cnt,
    input  o_lock, o_match, o_err, o_word_err_cnt, o_bit_err_cnt
  );

  modport slave (
    input  i_valid, i_lfsr, i_seed, i_seed_load, i_clr_cnt,
    output o_lock, o_match, o_err, o_word_err_cnt, o_bit_err_cnt
  );
endinterface

// File: rtl/lfsr_step.sv
// One combinational LFSR step, same function the generator uses.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = 8'h1D
) (
  input  logic [WIDTH-1:0] i_s,
  output logic [WIDTH-1:0] o_nxt
);

  assign o_nxt = WIDTH'(lfsr_next(32'(i_s), 32'(POLY), WIDTH));

endmodule

// File: rtl/lfsr_checker_param.sv
// PRBS receive checker: predicts the stream, locks after LOCK_CNT matches,
// flywheels through isolated errors and accumulates word/bit error counts.
module lfsr_checker_param
  import lfsr_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] POLY       = 8'h1D,
  parameter int               LOCK_CNT   = 5,
  parameter int               UNLOCK_CNT = 4,
  parameter int               CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 i_rst_n,
  lfsr_checker_param_if.slave  bus
);

  localparam logic [CNT_CW-1:0] LOCK_C   = CNT_CW'(LOCK_CNT);
  localparam logic [CNT_CW-1:0] UNLOCK_C = CNT_CW'(UNLOCK_CNT);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  state_e            r_state;
  logic [WIDTH-1:0]  r_exp;
  logic [CNT_CW-1:0] r_match_cnt, r_miss_cnt;
  logic              r_lock, r_match, r_err;
  logic [CNT_W-1:0]  r_word_err, r_bit_err;

  logic [WIDTH-1:0]  w_nxt_exp, w_nxt_rx, w_diff;
  logic [CNT_CW-1:0] w_match_inc, w_miss_inc;
  logic              w_hit, w_cnt_err;
  logic [CNT_W:0]    w_bit_sum;

  // Prediction advances from its own state; resync restarts from the received word.
  lfsr_step #(.WIDTH(WIDTH), .POLY(POLY)) u_step_exp (.i_s(r_exp),      .o_nxt(w_nxt_exp));
  lfsr_step #(.WIDTH(WIDTH), .POLY(POLY)) u_step_rx  (.i_s(bus.i_lfsr), .o_nxt(w_nxt_rx));

  assign w_diff      = bus.i_lfsr ^ r_exp;
  assign w_hit       = (w_diff == '0);
  assign w_match_inc = r_match_cnt + 1'b1;
  assign w_miss_inc  = r_miss_cnt + 1'b1;
  // Only mismatches while locked count; a seed load drops that cycle's sample.
  assign w_cnt_err   = bus.i_valid & ~bus.i_seed_load & (r_state == ST_LOCKED) & ~w_hit;
  // One spare bit catches overflow so the sum can clamp instead of wrapping.
  assign w_bit_sum   = {1'b0, r_bit_err} + (CNT_W+1)'(popcount(32'(w_diff)));

  // Lock FSM, prediction register and registered status flags.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_UNLOCKED;
      r_exp       <= '0;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
      r_lock      <= 1'b0;
      r_match     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (bus.i_seed_load) begin
        r_exp       <= bus.i_seed;
        r_state     <= ST_UNLOCKED;
        r_match_cnt <= '0;
        r_miss_cnt  <= '0;
        r_lock      <= 1'b0;
        r_match     <= 1'b0;
      end else if (bus.i_valid) begin
        r_match <= w_hit;
        case (r_state)
          ST_UNLOCKED: begin
            if (w_hit) begin
              r_exp <= w_nxt_exp;
              if (w_match_inc == LOCK_C) begin
                r_state     <= ST_LOCKED;
                r_lock      <= 1'b1;
                r_match_cnt <= '0;
                r_miss_cnt  <= '0;
              end else begin
                r_match_cnt <= w_match_inc;
              end
            end else begin
              r_exp       <= w_nxt_rx;
              r_match_cnt <= '0;
            end
          end
          ST_LOCKED: begin
            if (w_hit) begin
              r_exp      <= w_nxt_exp;
              r_miss_cnt <= '0;
            end else begin
              r_err <= 1'b1;
              if (w_miss_inc == UNLOCK_C) begin
                r_state     <= ST_UNLOCKED;
                r_lock      <= 1'b0;
                r_exp       <= w_nxt_rx;
                r_match_cnt <= '0;
                r_miss_cnt  <= '0;
              end else begin
                r_exp      <= w_nxt_exp;
                r_miss_cnt <= w_miss_inc;
              end
            end
          end
          default: r_state <= ST_UNLOCKED;
        endcase
      end
    end
  end

  // Saturating BER counters; a clear in the same cycle beats the increment.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_word_err <= '0;
      r_bit_err  <= '0;
    end else if (bus.i_clr_cnt) begin
      r_word_err <= '0;
      r_bit_err  <= '0;
    end else if (w_cnt_err) begin
      if (r_word_err != CNT_MAX) r_word_err <= r_word_err + 1'b1;
      r_bit_err <= w_bit_sum[CNT_W] ? CNT_MAX : w_bit_sum[CNT_W-1:0];
    end
  end

  assign bus.o_lock         = r_lock;
  assign bus.o_match        = r_match;
  assign bus.o_err          = r_err;
  assign bus.o_word_err_cnt = r_word_err;
  assign bus.o_bit_err_cnt  = r_bit_err;

endmodule
